// File: rtl/serial_mem_pkg.sv
// serial_mem_pkg: shared constants and types for the serial RAM read path.
//   DEF_* constants are the default pin counts, slot length and RAM response
//   delay. The CYCLES, ADDR_BITS and DATA_BITS values are derived from them.
//   The tag type is used only when SERIAL_MEM_TAG_EN is defined.
package serial_mem_pkg;

  localparam int DEF_ADDR_PINS   = 4;
  localparam int DEF_DATA_PINS   = 4;
  localparam int DEF_LOG2_CYCLES = 2;
  localparam int DEF_RESP_DELAY  = 6;

  localparam int DEF_CYCLES    = 2 ** DEF_LOG2_CYCLES;
  localparam int DEF_ADDR_BITS = DEF_ADDR_PINS * DEF_CYCLES;
  localparam int DEF_DATA_BITS = DEF_DATA_PINS * DEF_CYCLES;

  localparam int TAG_BITS = 4;

  typedef logic [TAG_BITS-1:0] tag_t;

endpackage

// File: rtl/serial_mem_deser.sv
// serial_mem_deser: collects the data nibbles returned by the serial RAM into
// a full response word.
//   clk, reset  clock and asynchronous active-high reset
//   load_en     sample data_in this cycle (a read's nibble is on the pins)
//   done_en     this cycle carries the last nibble of a read
//   data_in     serial data pins from the RAM
//   word_out    completed word, held until the next completion
//   done_out    one-cycle strobe, aligned with word_out updating
module serial_mem_deser #(
  parameter int DATA_PINS = 4,
  parameter int CYCLES    = 4,
  localparam int DATA_BITS = DATA_PINS * CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_en,
  input  logic                 done_en,
  input  logic [DATA_PINS-1:0] data_in,
  output logic [DATA_BITS-1:0] word_out,
  output logic                 done_out
);

  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] word_q, word_d;
  logic                 done_q, done_d;

  // The LSB nibble arrives first. Each new nibble enters at the top, so after
  // CYCLES shifts the first nibble sits at the bottom of the word.
  always_comb begin
    shift_d = shift_q;
    if (load_en) begin
      shift_d = {data_in, shift_q[DATA_BITS-1:DATA_PINS]};
    end
    word_d = done_en ? shift_d : word_q;
    done_d = done_en;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      done_q  <= done_d;
    end
  end

  assign word_out = word_q;
  assign done_out = done_q;

endmodule

// File: rtl/serial_mem_reader.sv
// serial_mem_reader: read-side controller for the serial RAM link.
//   Each parallel read request is sent as nibble-serial address slots, one slot
//   every CYCLES clocks. The returned data nibbles are then rebuilt into a full
//   response word.
//   clk, reset          clock and asynchronous active-high reset
//   req_valid/req_ready request handshake; ready only in the last slot phase
//   req_addr            read address
//   addr_out            registered serial address pins, LSB nibble first
//   data_in             serial data pins from the RAM
//   rsp_valid/rsp_data  one-cycle completion pulse and held read data
// Optional macro SERIAL_MEM_TAG_EN adds req_tag/rsp_tag. The tag travels with
// each in-flight read.
module serial_mem_reader
  import serial_mem_pkg::*;
#(
  parameter int ADDR_PINS   = DEF_ADDR_PINS,
  parameter int DATA_PINS   = DEF_DATA_PINS,
  parameter int LOG2_CYCLES = DEF_LOG2_CYCLES,
  parameter int RESP_DELAY  = DEF_RESP_DELAY,
  localparam int CYCLES    = 2 ** LOG2_CYCLES,
  localparam int ADDR_BITS = ADDR_PINS * CYCLES,
  localparam int DATA_BITS = DATA_PINS * CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_BITS-1:0] req_addr,
  output logic [ADDR_PINS-1:0] addr_out,
  input  logic [DATA_PINS-1:0] data_in,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data
`ifdef SERIAL_MEM_TAG_EN
  ,
  input  tag_t                 req_tag,
  output tag_t                 rsp_tag
`endif
);

  localparam int DEPTH = RESP_DELAY + CYCLES;
  localparam logic [LOG2_CYCLES-1:0] PH_LAST = '1;

  logic [LOG2_CYCLES-1:0] ph_q, ph_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   busy_q, busy_d;
  logic [ADDR_PINS-1:0]   addr_out_q, addr_out_d;
  // Bit k is set while an accepted read is k clocks past its first address nibble.
  logic [DEPTH-1:0]       flight_q, flight_d;
  logic                   accept;
  logic                   load_en;
  logic                   done_en;

  assign req_ready = (ph_q == PH_LAST);
  assign accept    = req_valid && req_ready;

  // addr_out is registered, so each edge loads the nibble for the next phase.
  // The accepting edge loads nibble 0 for the new slot.
  always_comb begin
    ph_d       = ph_q + 1'b1;
    addr_d     = addr_q;
    busy_d     = busy_q;
    addr_out_d = '0;
    flight_d   = {flight_q[DEPTH-2:0], accept};
    if (req_ready) begin
      busy_d = accept;
      if (accept) begin
        addr_d     = req_addr;
        addr_out_d = req_addr[ADDR_PINS-1:0];
      end
    end else if (busy_q) begin
      addr_out_d = addr_q[ph_d*ADDR_PINS +: ADDR_PINS];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_q       <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      addr_out_q <= '0;
      flight_q   <= '0;
    end else begin
      ph_q       <= ph_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      addr_out_q <= addr_out_d;
      flight_q   <= flight_d;
    end
  end

  assign addr_out = addr_out_q;

  // Read data nibbles are on the pins RESP_DELAY..RESP_DELAY+CYCLES-1 clocks
  // after the slot starts. Back-to-back slots keep these windows contiguous
  // and aligned.
  assign load_en = |flight_q[RESP_DELAY +: CYCLES];
  assign done_en = flight_q[DEPTH-1];

  serial_mem_deser #(
    .DATA_PINS (DATA_PINS),
    .CYCLES    (CYCLES)
  ) u_deser (
    .clk      (clk),
    .reset    (reset),
    .load_en  (load_en),
    .done_en  (done_en),
    .data_in  (data_in),
    .word_out (rsp_data),
    .done_out (rsp_valid)
  );

`ifdef SERIAL_MEM_TAG_EN
  logic [DEPTH-1:0][TAG_BITS-1:0] tag_pipe_q, tag_pipe_d;
  tag_t                           rsp_tag_q, rsp_tag_d;

  always_comb begin
    tag_pipe_d = {tag_pipe_q[DEPTH-2:0], (accept ? req_tag : tag_t'(0))};
    rsp_tag_d  = done_en ? tag_pipe_q[DEPTH-1] : rsp_tag_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_pipe_q <= '0;
      rsp_tag_q  <= '0;
    end else begin
      tag_pipe_q <= tag_pipe_d;
      rsp_tag_q  <= rsp_tag_d;
    end
  end

  assign rsp_tag = rsp_tag_q;
`endif

endmodule
